// File: rtl/cve2_hpm_counter_bank_pkg.sv
// rtl/cve2_hpm_counter_bank_pkg.sv - CSR offsets, limits and event encoding for the HPM counter bank
package cve2_hpm_counter_bank_pkg;

  localparam logic [11:0] CSR_OFF_MHPMEVENT    = 12'h320;
  localparam logic [11:0] CSR_OFF_MHPMCOUNTER  = 12'hB00;
  localparam logic [11:0] CSR_OFF_MHPMCOUNTERH = 12'hB80;

  localparam int unsigned MHPM_MAX_COUNTERS = 29;

  typedef enum logic [4:0] {
    HPM_EV_CYCLE        = 5'd0,
    HPM_EV_INSTRET      = 5'd1,
    HPM_EV_LOAD         = 5'd2,
    HPM_EV_STORE        = 5'd3,
    HPM_EV_JUMP         = 5'd4,
    HPM_EV_BRANCH       = 5'd5,
    HPM_EV_BRANCH_TAKEN = 5'd6,
    HPM_EV_MULDIV_WAIT  = 5'd7,
    HPM_EV_LSU_WAIT     = 5'd8,
    HPM_EV_IF_WAIT      = 5'd9
  } hpm_event_e;

  // All bank registers sit in 32-entry aligned windows; bits [11:5] name the window.
  function automatic logic [6:0] csr_window(logic [11:0] addr);
    return addr[11:5];
  endfunction

endpackage

// File: rtl/cve2_hpm_counter_bank_counter.sv
// rtl/cve2_hpm_counter_bank_counter.sv - one HPM counter channel with write priority and sticky wrap flag
module cve2_hpm_counter #(
  parameter int unsigned Width = 40
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        inc_i,
  input  logic        we_lo_i,
  input  logic        we_hi_i,
  input  logic [31:0] wdata_i,
  output logic [63:0] value_o,
  output logic        overflow_o
);

  logic [Width-1:0] cnt_q;
  logic [63:0]      cur;
  logic [63:0]      nxt;
  logic             ovf_q;
  logic             unused_nxt;

  assign cur = 64'(cnt_q);

  // Writes are merged into a 64-bit view and truncated, so bits beyond Width drop out
  // and a high-half write on a narrow counter has no effect.
  always_comb begin
    nxt = cur;
    if (we_lo_i) nxt[31:0]  = wdata_i;
    if (we_hi_i) nxt[63:32] = wdata_i;
  end

  assign unused_nxt = ^nxt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else if (we_lo_i || we_hi_i) begin
      cnt_q <= nxt[Width-1:0];
      ovf_q <= 1'b0;
    end else if (inc_i) begin
      cnt_q <= cnt_q + Width'(1);
      if (&cnt_q) ovf_q <= 1'b1;
    end
  end

  assign value_o    = cur;
  assign overflow_o = ovf_q;

endmodule

// File: rtl/cve2_hpm_counter_bank.sv
// rtl/cve2_hpm_counter_bank.sv - parametrised mhpmcounter/mhpmevent/mcountinhibit CSR bank
module cve2_hpm_counter_bank
  import cve2_hpm_counter_bank_pkg::*;
#(
  parameter int unsigned NumCounters  = 10,
  parameter int unsigned CounterWidth = 40,
  parameter int unsigned NumEvents    = 16,
  localparam int unsigned NumImpl = (NumCounters > MHPM_MAX_COUNTERS) ? MHPM_MAX_COUNTERS : NumCounters,
  localparam int unsigned NC      = (NumImpl == 0) ? 1 : NumImpl
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [11:0]          csr_addr_i,
  input  logic                 csr_we_i,
  input  logic [31:0]          csr_wdata_i,
  output logic                 csr_hit_o,
  output logic [31:0]          csr_rdata_o,
  input  logic [NumEvents-1:0] events_i,
  input  logic                 debug_mode_i,
  input  logic                 stopcount_i,
  output logic [NC-1:0]        overflow_o
);

  logic [6:0]           win;
  logic [4:0]           idx;
  logic                 chan_ok;
  logic                 is_evt;
  logic                 is_cnt;
  logic                 is_cnth;
  logic                 is_inh;
  logic                 stop;
  logic [NC-1:0]        inhibit_q;
  logic [NumEvents-1:0] mask_q [NC];
  logic [63:0]          values [NC];

  assign win     = csr_window(csr_addr_i);
  assign idx     = csr_addr_i[4:0];
  assign chan_ok = (idx >= 5'd3) && (32'(idx) <= NumImpl + 2);
  assign is_evt  = (win == csr_window(CSR_OFF_MHPMEVENT)) && chan_ok;
  assign is_cnt  = (win == csr_window(CSR_OFF_MHPMCOUNTER)) && chan_ok;
  assign is_cnth = (win == csr_window(CSR_OFF_MHPMCOUNTERH)) && chan_ok;
  assign is_inh  = (csr_addr_i == CSR_OFF_MHPMEVENT);
  assign stop    = debug_mode_i & stopcount_i;

  assign csr_hit_o = is_evt | is_cnt | is_cnth | is_inh;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      inhibit_q <= '0;
    end else if (csr_we_i && is_inh) begin
      inhibit_q <= csr_wdata_i[NC+2:3];
    end
  end

  for (genvar i = 0; i < NC; i++) begin : g_chan
    logic sel;
    logic inc;

    assign sel = chan_ok && (32'(idx) == 32'(i + 3));
    assign inc = (|(events_i & mask_q[i])) & ~inhibit_q[i] & ~stop;

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        mask_q[i] <= '0;
      end else if (csr_we_i && is_evt && sel) begin
        mask_q[i] <= csr_wdata_i[NumEvents-1:0];
      end
    end

    cve2_hpm_counter #(
      .Width(CounterWidth)
    ) u_counter (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .inc_i     (inc),
      .we_lo_i   (csr_we_i && is_cnt && sel),
      .we_hi_i   (csr_we_i && is_cnth && sel),
      .wdata_i   (csr_wdata_i),
      .value_o   (values[i]),
      .overflow_o(overflow_o[i])
    );
  end

  always_comb begin
    csr_rdata_o = '0;
    if (is_inh && NumImpl > 0) csr_rdata_o = 32'(inhibit_q) << 3;
    for (int i = 0; i < NC; i++) begin
      if (chan_ok && (32'(idx) == 32'(i + 3))) begin
        if (is_evt)  csr_rdata_o = 32'(mask_q[i]);
        if (is_cnt)  csr_rdata_o = values[i][31:0];
        if (is_cnth) csr_rdata_o = values[i][63:32];
      end
    end
  end

endmodule
